// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
// Shared definitions for the 3x3 median filter front end: default geometry
// parameters and the window-builder FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package median_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_IMAGE_WIDTH = 10;

    // IDLE: waiting for start of frame; FILL: rows 0 and 1 loading the line
    // buffers; RUN: rows >= 2, complete windows can be emitted.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One-line delay addressed by column. Reading column c returns the pixel that
// was last written at column c (i.e. the previous line), and the same cycle's
// write replaces it. Columns skipped by a short line keep their old contents.
// Storage is not reset.
// Ports:
//   i_clk   in   clock
//   i_we    in   write enable (accepted pixel)
//   i_addr  in   column of the current pixel
//   i_data  in   pixel to store
//   o_data  out  pixel stored at i_addr before this write
// ---------------------------------------------------------------------------
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic [DATA_WIDTH-1:0]    o_data
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_data;
        end
    end

    assign o_data = mem[i_addr];

endmodule

// File: rtl/kernel_window_3x3.sv
// ---------------------------------------------------------------------------
// kernel_window_3x3
// Builds 3x3 pixel windows from an AXI4-Stream pixel stream for the median
// stage. Window [i][j] = pixel(r-2+i, c-2+j); one window per accepted pixel at
// row >= 2, col >= 2 (no border padding). Only KERNEL_SIZE = 3 is supported.
// Ports:
//   i_clk                  in   clock, rising edge
//   i_aresetn              in   asynchronous active-low reset
//   s_axis_tdata           in   pixel
//   s_axis_tvalid          in   pixel valid
//   s_axis_tready          out  always 1 out of reset
//   s_axis_tuser           in   start of frame (first pixel)
//   s_axis_tlast           in   end of line (last pixel of a line)
//   o_image_kernel_buffer  out  3x3 window, held between valid pulses
//   o_image_data_valid     out  one-cycle pulse per window
//   o_start_of_frame       out  with the first window of a frame
//   dbg_state              out  FSM state for observation
// Handshake: a pixel is transferred on a rising edge where s_axis_tvalid and
// s_axis_tready are both 1; with tvalid low nothing advances.
// ---------------------------------------------------------------------------
module kernel_window_3x3
    import median_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel_buffer,
    output logic                  o_image_data_valid,
    output logic                  o_start_of_frame,
    output state_t                dbg_state
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = 16;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);

    typedef logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] window_t;

    state_t                 state, state_next;
    logic [COL_W-1:0]       col, col_next, beat_col;
    logic [ROW_W-1:0]       row, row_next, beat_row;
    logic                   accept, store, wrap, fire, sof_pending;
    logic [DATA_WIDTH-1:0]  up, upup;
    logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] new_column;
    window_t                taps, taps_next;

    // No downstream backpressure: ready follows reset directly so it drops
    // the instant reset asserts.
    assign s_axis_tready = i_aresetn;
    assign accept        = s_axis_tvalid & s_axis_tready;
    // In IDLE only a start-of-frame pixel is kept; everything else is dropped.
    assign store         = accept & (s_axis_tuser | (state != ST_IDLE));
    // A start-of-frame pixel is always (0,0), whatever the counters held.
    assign beat_col      = s_axis_tuser ? '0 : col;
    assign beat_row      = s_axis_tuser ? '0 : row;
    assign wrap          = s_axis_tlast | (beat_col == LAST_COL);
    assign fire          = accept & ~s_axis_tuser & (state == ST_RUN) &
                           (row >= ROW_W'(2)) & (col >= COL_W'(2));
    assign dbg_state     = state;

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_line_1 (
        .i_clk  (i_clk),
        .i_we   (store),
        .i_addr (beat_col),
        .i_data (s_axis_tdata),
        .o_data (up)
    );

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_line_2 (
        .i_clk  (i_clk),
        .i_we   (store),
        .i_addr (beat_col),
        .i_data (up),
        .o_data (upup)
    );

    // Newest column: top = two lines back, bottom = current pixel.
    assign new_column = {upup, up, s_axis_tdata};

    always_comb begin
        taps_next = taps;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                taps_next[i][j] = taps[i][j+1];
            end
            taps_next[i][KERNEL_SIZE-1] = new_column[i];
        end
    end

    // Next-state and position counters.
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        if (store) begin
            if (wrap) begin
                col_next = '0;
                // Saturate so an over-long frame never falls back below row 2.
                row_next = (&beat_row) ? beat_row : beat_row + 1'b1;
            end else begin
                col_next = beat_col + 1'b1;
                row_next = beat_row;
            end
            if (s_axis_tuser) begin
                state_next = ST_FILL;
            end else if (state == ST_FILL && wrap && beat_row == ROW_W'(1)) begin
                state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            taps                  <= '0;
            sof_pending           <= 1'b0;
            o_image_kernel_buffer <= '0;
            o_image_data_valid    <= 1'b0;
            o_start_of_frame      <= 1'b0;
        end else begin
            if (store) begin
                taps <= taps_next;
            end
            if (store && s_axis_tuser) begin
                sof_pending <= 1'b1;
            end else if (fire) begin
                sof_pending <= 1'b0;
            end
            o_image_data_valid <= fire;
            o_start_of_frame   <= fire & sof_pending;
            if (fire) begin
                o_image_kernel_buffer <= taps_next;
            end
        end
    end

endmodule

// File: tb/tb_kernel_window_3x3.sv
module tb_kernel_window_3x3;

  localparam int W  = 10;
  localparam int DW = 8;

  typedef logic [0:2][0:2][DW-1:0] win_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]        tdata = '0;
  logic                 tvalid = 1'b0;
  logic                 tuser = 1'b0;
  logic                 tlast = 1'b0;
  logic                 tready;
  win_t                 win_o;
  logic                 valid_o;
  logic                 sof_o;
  median_pkg::state_t   dbg;

  kernel_window_3x3 #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .IMAGE_WIDTH(W)) dut (
    .i_clk                 (clk),
    .i_aresetn             (rst_n),
    .s_axis_tdata          (tdata),
    .s_axis_tvalid         (tvalid),
    .s_axis_tready         (tready),
    .s_axis_tuser          (tuser),
    .s_axis_tlast          (tlast),
    .o_image_kernel_buffer (win_o),
    .o_image_data_valid    (valid_o),
    .o_start_of_frame      (sof_o),
    .dbg_state             (dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic win_t win_lit(input int a, input int b, input int c,
                                   input int d, input int e, input int f,
                                   input int g, input int h, input int k);
    win_t w;
    w[0][0] = DW'(a); w[0][1] = DW'(b); w[0][2] = DW'(c);
    w[1][0] = DW'(d); w[1][1] = DW'(e); w[1][2] = DW'(f);
    w[2][0] = DW'(g); w[2][1] = DW'(h); w[2][2] = DW'(k);
    return w;
  endfunction

  // ---------------- reference model ----------------
  // Frame position is tracked from the stream rules; each column keeps the
  // history of pixels written to it, so "one line up" is simply the previous
  // entry at that column (stale entries survive short lines and restarts).
  logic [DW:0+3*3*DW] exp_q_unused;
  logic [3*3*DW:0] exp_q[$];   // {sof, window}
  bit              exp_due;
  bit              m_active;
  bit              m_sof_pend;
  int              m_row, m_col;
  logic [DW-1:0]   hist[W][$];
  logic [DW-1:0]   cur[3][W];

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] up, upup;
    win_t w;
    if (!rst_n) begin
      m_active   = 1'b0;
      m_sof_pend = 1'b0;
      m_row      = 0;
      m_col      = 0;
      exp_due    = 1'b0;
      exp_q.delete();
    end else begin
      exp_due = 1'b0;
      if (tvalid) begin
        if (tuser) begin
          m_active   = 1'b1;
          m_row      = 0;
          m_col      = 0;
          m_sof_pend = 1'b1;
        end
        if (m_active) begin
          up   = (hist[m_col].size() >= 1) ? hist[m_col][hist[m_col].size()-1] : '0;
          upup = (hist[m_col].size() >= 2) ? hist[m_col][hist[m_col].size()-2] : '0;
          cur[0][m_col] = upup;
          cur[1][m_col] = up;
          cur[2][m_col] = tdata;
          hist[m_col].push_back(tdata);
          if (hist[m_col].size() > 2) void'(hist[m_col].pop_front());
          if (m_row >= 2 && m_col >= 2) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                w[i][j] = cur[i][m_col-2+j];
            exp_q.push_back({m_sof_pend, w});
            m_sof_pend = 1'b0;
            exp_due    = 1'b1;
          end
          if (tlast || m_col == W-1) begin
            m_col = 0;
            m_row++;
          end else begin
            m_col++;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  win_t last_win = '0;
  win_t obs_q[$];
  int   sof_cnt = 0;

  always @(negedge clk) begin
    logic [3*3*DW:0] e;
    if (!rst_n) begin
      check("rst_tready", tready, 0);
      check("rst_valid", valid_o, 0);
      check("rst_sof", sof_o, 0);
      check("rst_window", win_o, 0);
      check("rst_state", dbg, median_pkg::ST_IDLE);
      last_win = '0;
    end else begin
      check("tready", tready, 1);
      check("valid", valid_o, exp_due);
      if (exp_due && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_win = e[3*3*DW-1:0];
        if (valid_o) begin
          check("window", win_o, e[3*3*DW-1:0]);
          check("sof", sof_o, e[3*3*DW]);
        end
      end else begin
        check("hold_window", win_o, last_win);
        check("sof_idle", sof_o, 0);
      end
      if (valid_o) begin
        obs_q.push_back(win_o);
        if (sof_o) sof_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
      tuser  = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic u, input logic l);
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    tlast  = l;
  endtask

  // mode 0: continuous, 1: tvalid toggles every cycle, 2: random gaps.
  // Stops without driving (stop_r, stop_c) when that position is reached.
  task automatic send_frame(input int h, input int mode, input bit rnd, input bit short_ok,
                            input int stop_r, input int stop_c);
    int len;
    logic [DW-1:0] d;
    logic last;
    for (int r = 0; r < h; r++) begin
      len = W;
      if (short_ok && $urandom_range(0, 3) == 0) len = $urandom_range(1, W-1);
      for (int c = 0; c < len; c++) begin
        if (r == stop_r && c == stop_c) return;
        d    = rnd ? DW'($urandom_range(0, 255)) : DW'(10*r + c);
        last = (c == len-1) && (len < W || !rnd || $urandom_range(0, 1) == 1);
        if (mode == 1) idle(1);
        else if (mode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        beat(d, (r == 0 && c == 0), last);
      end
    end
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) beat(DW'($urandom_range(0, 255)), 1'b0, i[0]);
  endtask

  // ---------------- stimulus ----------------
  win_t ref_q[$];
  win_t first_lit, last_lit;

  initial begin
    first_lit = win_lit(0, 1, 2, 10, 11, 12, 20, 21, 22);
    last_lit  = win_lit(17, 18, 19, 27, 28, 29, 37, 38, 39);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Junk before any start of frame, then a 10x4 ramp frame.
    obs_q.delete(); sof_cnt = 0;
    junk(5);
    send_frame(4, 0, 1'b0, 1'b0, -1, -1);
    idle(3);
    check("ramp_count", obs_q.size(), 16);
    check("ramp_sof_count", sof_cnt, 1);
    if (obs_q.size() == 16) begin
      check("ramp_first", obs_q[0], first_lit);
      check("ramp_last", obs_q[15], last_lit);
    end
    ref_q = obs_q;

    // Same frame with tvalid toggling.
    obs_q.delete(); sof_cnt = 0;
    send_frame(4, 1, 1'b0, 1'b0, -1, -1);
    idle(3);
    check("toggle_count", obs_q.size(), 16);
    check("toggle_sof_count", sof_cnt, 1);
    for (int i = 0; i < 16 && i < obs_q.size() && i < ref_q.size(); i++)
      check($sformatf("toggle_win%0d", i), obs_q[i], ref_q[i]);

    // Restart at (3,4): 8 + 2 windows from the aborted frame, then 16.
    obs_q.delete(); sof_cnt = 0;
    send_frame(4, 0, 1'b0, 1'b0, 3, 4);
    send_frame(4, 0, 1'b0, 1'b0, -1, -1);
    idle(3);
    check("restart_count", obs_q.size(), 26);
    check("restart_sof_count", sof_cnt, 2);
    if (obs_q.size() == 26) begin
      check("restart_pre", obs_q[9], win_lit(11, 12, 13, 21, 22, 23, 31, 32, 33));
      check("restart_first", obs_q[10], first_lit);
      check("restart_last", obs_q[25], last_lit);
    end

    // Asynchronous reset during row 2, right after the (2,4) window fires.
    send_frame(4, 0, 1'b0, 1'b0, 2, 5);
    @(posedge clk);
    #2;
    check("pre_reset_valid", valid_o, 1);
    rst_n  = 1'b0;
    tvalid = 1'b0;
    #1;
    check("async_valid", valid_o, 0);
    check("async_window", win_o, 0);
    check("async_tready", tready, 0);
    check("async_sof", sof_o, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    obs_q.delete(); sof_cnt = 0;
    junk(12);
    idle(2);
    check("post_reset_quiet", obs_q.size(), 0);
    send_frame(4, 0, 1'b0, 1'b0, -1, -1);
    idle(3);
    check("post_reset_count", obs_q.size(), 16);
    if (obs_q.size() > 0) check("post_reset_first", obs_q[0], first_lit);

    // Randomized frames: random data, gaps, heights, short lines.
    for (int f = 0; f < 8; f++) begin
      send_frame($urandom_range(3, 6), (f % 3 == 0) ? 0 : 2, 1'b1, (f >= 2), -1, -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(4);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/kernel_window_3x3.md
KERNEL_WINDOW_3X3 -- requirements
Module: kernel_window_3x3

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter KERNEL_SIZE, default 3, meaning window edge; only 3 is supported.
REQ-003 The block SHALL have parameter IMAGE_WIDTH, default 10, meaning pixels per line, range 3..4096.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_aresetn  in  1  asynchronous, active-low reset.
REQ-006 s_axis_tdata  in  DATA_WIDTH  input pixel.
REQ-007 s_axis_tvalid  in  1  pixel valid.
REQ-008 s_axis_tready  out  1  block accepts pixel.
REQ-009 s_axis_tuser  in  1  start of frame; marks the first pixel of a frame.
REQ-010 s_axis_tlast  in  1  end of line; marks the last pixel of a line.
REQ-011 o_image_kernel_buffer  out  DATA_WIDTH x [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1]  3x3 window feeding median_processing_3x3.
REQ-012 o_image_data_valid  out  1  window valid, single-cycle per window.
REQ-013 o_start_of_frame  out  1  first valid window of the frame.

Function
REQ-014 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1; s_axis_tready SHALL be 1 whenever out of reset, because the downstream stage has no backpressure.
REQ-015 The FSM SHALL have states IDLE, FILL and RUN, and SHALL reset to IDLE.
REQ-016 In IDLE, accepted beats with tuser=0 SHALL be discarded; a beat with tuser=1 SHALL be taken as pixel (row 0, col 0), and the FSM SHALL enter FILL.
REQ-017 Column counter col SHALL increment per accepted beat and SHALL wrap to 0 (row+1) after the beat with tlast=1 or at col=IMAGE_WIDTH-1, whichever comes first.
REQ-018 FSM SHALL go FILL->RUN at the wrap out of row 1; RUN SHALL persist until the next tuser.
REQ-019 An accepted beat with tuser=1 in any state SHALL restart the frame: col=0, row=0, FILL, pixel stored as (0,0); line buffer contents need not be cleared.
REQ-020 Two line buffers SHALL delay the pixel stream by one and two lines; a 3x3 shift register SHALL hold the last three columns of rows r-2, r-1, r.
REQ-021 Window mapping: [0][*]=row r-2, [2][*]=row r, column index 2 = newest pixel, so the window is [i][j]=pixel(r-2+i, c-2+j).
REQ-022 o_image_data_valid SHALL pulse exactly 1 cycle after an accepted beat at (r,c) with state RUN, r>=2 and c>=2; no border padding, so windows SHALL number (H-2)*(IMAGE_WIDTH-2) per frame.
REQ-023 o_start_of_frame SHALL be 1 only together with the first o_image_data_valid pulse after a tuser, at (2,2).
REQ-024 o_image_kernel_buffer SHALL hold its value when o_image_data_valid=0.
REQ-025 A gap in tvalid SHALL freeze all counters, buffers and the window; no output SHALL be produced during the gap.
REQ-026 A short line (tlast before col=IMAGE_WIDTH-1) SHALL wrap early; line buffer columns not written in that line SHALL keep stale data.

Reset
REQ-027 On i_aresetn=0, all outputs SHALL be 0 immediately, including s_axis_tready, the window and the valid flags; the FSM SHALL enter IDLE and col/row SHALL be 0.
REQ-028 Reset mid-frame SHALL discard the frame; the block SHALL wait for a new tuser after reset release.
REQ-029 Line buffer storage SHALL not require reset.

Structure
REQ-030 The shared package median_pkg SHALL hold the DATA_WIDTH/KERNEL_SIZE/IMAGE_WIDTH defaults and the state enum typedef.
REQ-031 The block SHALL use one sub-module, line_buffer: an IMAGE_WIDTH-deep single-clock delay with a write enable, instantiated twice.

Verification
REQ-032 10x4 frame, pixel=10*row+col, tvalid constant -> first window at the cycle after (2,2) is accepted, value {0,1,2},{10,11,12},{20,21,22}, with o_start_of_frame=1.
REQ-033 Same frame -> exactly 16 valid pulses; the last window is {17,18,19},{27,28,29},{37,38,39}; o_start_of_frame is 1 only once.
REQ-034 Same frame with tvalid toggling 1/0 every cycle -> identical window sequence; the window holds during gaps.
REQ-035 Five beats before any tuser, then the frame -> the first five beats are ignored; output is as in REQ-032.
REQ-036 tuser reasserted at (3,4) -> restart; no valid pulse until the new (2,2); o_start_of_frame pulses again.
REQ-037 i_aresetn low during row 2 -> all outputs 0 asynchronously; after release, no output until tuser.
